// File: rtl/poly_pkg.sv
// ============================================================================
//  Module   : poly_pkg
//  Purpose  : Ring constants and stream-stage state encoding shared by the
//             NTT/INTT, pointwise-multiply and scaling stages.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package poly_pkg;

    localparam int          W    = 16;
    localparam int          N    = 16;
    localparam int          IW   = $clog2(N);
    localparam logic [15:0] Q    = 16'h1E01;
    // 16 * 7201 = 115216 = 15 * 7681 + 1
    localparam logic [15:0] NINV = 16'd7201;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage : poly_pkg

`default_nettype wire

// File: rtl/mod_mul_const.sv
// ============================================================================
//  Module   : mod_mul_const
//  Purpose  : Combinational (a * NINV) mod Q using a Barrett reduction.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mod_mul_const
    import poly_pkg::*;
(
    input  logic [W-1:0] a_i,
    output logic [W-1:0] p_o
);

    // Product is below 2^29, so with K = 42 the quotient estimate is low by
    // at most one and a single conditional subtract completes the reduction.
    localparam int unsigned K   = 42;
    localparam logic [29:0] c_M = 30'((64'd1 << K) / {48'd0, Q});

    logic [29:0] w_prod;
    logic [59:0] w_mq;
    logic [17:0] w_qest;
    logic [29:0] w_rem;

    assign w_prod = {14'd0, a_i} * 30'(NINV);
    assign w_mq   = {30'd0, w_prod} * {30'd0, c_M};
    assign w_qest = 18'(w_mq >> K);
    assign w_rem  = w_prod - 30'(w_qest) * 30'(Q);
    assign p_o    = (w_rem >= 30'(Q)) ? W'(w_rem - 30'(Q)) : W'(w_rem);

endmodule : mod_mul_const

`default_nettype wire

// File: rtl/intt_scale_stream.sv
// ============================================================================
//  Module   : intt_scale_stream
//  Purpose  : Scales a captured INTT vector by N^-1 mod Q and streams the
//             coefficients out one per cycle with backpressure.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module intt_scale_stream
    import poly_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*W-1:0] in_coeffs,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic          busy
);

    localparam logic [IW:0] c_RD_END  = (IW+1)'(N);
    localparam logic [IW:0] c_RD_LAST = (IW+1)'(N - 1);

    state_e                   state_q, state_d;
    logic [N-1:0][W-1:0]      coef_q, coef_d;
    logic [IW:0]              rd_q, rd_d;
    logic [W-1:0]             data_q, data_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     last_q, last_d;
    logic                     valid_q, valid_d;

    logic [W-1:0]             w_operand;
    logic [W-1:0]             w_scaled;
    logic                     w_hs;

    // Coefficient 0 is scaled straight from the input bus on the accept edge,
    // so the first output is valid in the cycle right after acceptance.
    assign w_operand = (state_q == IDLE) ? in_coeffs[W-1:0] : coef_q[rd_q[IW-1:0]];
    assign w_hs      = valid_q && out_ready;

    mod_mul_const u_mod_mul (
        .a_i (w_operand),
        .p_o (w_scaled)
    );

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        rd_d    = rd_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    coef_d  = in_coeffs;
                    data_d  = w_scaled;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = (IW+1)'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_q < c_RD_END) begin
                    if (!valid_q || out_ready) begin
                        data_d  = w_scaled;
                        idx_d   = rd_q[IW-1:0];
                        last_d  = (rd_q == c_RD_LAST);
                        valid_d = 1'b1;
                        rd_d    = rd_q + (IW+1)'(1);
                    end
                end else if (w_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            coef_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign out_last  = last_q;

endmodule : intt_scale_stream

`default_nettype wire

// File: doc/intt_scale_stream.md
Name: intt_scale_stream

Overview:
- Downstream stage of the inverse-NTT block in the polynomial multiplier.
- Accepts one 16-coefficient INTT result vector through a valid/ready handshake.
- Multiplies each coefficient by N^-1 mod q (q = 0x1E01 = 7681, N = 16) to complete the inverse transform.
- Streams the scaled coefficients out one per cycle, index 0 first, with backpressure.

Parameters:
- Q, 7681, ring modulus (matches the multiplier's modulo_ring 16'h1e01).
- N, 16, coefficients per polynomial.
- NINV, 7201, N^-1 mod Q (16*7201 = 115216 ≡ 1 mod 7681).
- W, 16, coefficient width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_coeffs holds a complete INTT vector.
- in_ready  output  1  block can accept a vector.
- in_coeffs  input  N*W (256)  coefficient k at bits [16k+15:16k]; any 16-bit value is legal.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  (coef * NINV) mod Q, always < Q.
- out_index  output  4  index of the coefficient on out_data.
- out_last  output  1  high with index N-1.
- busy  output  1  high from vector accept until the last output handshake.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; in_ready = 1; out_valid = 0; out_data = 0; out_index = 0; out_last = 0; busy = 0.
  - The coefficient buffer and read counter are cleared.
- Reset mid-stream drops the vector; no partial output resumes after reset.
- Accept: when in_valid && in_ready on an edge, all 256 bits are captured into the buffer.
  - Counter rd = 0; state goes to RUN; in_ready drops next cycle; busy rises.
- States:
  - IDLE: in_ready = 1. Accept goes to RUN.
  - RUN: in_ready = 0. The output register is loaded whenever it is empty or out_ready = 1, and rd < N.
    - Load: out_data = (buf[rd] * NINV) mod Q; out_index = rd; out_last = (rd == N-1); out_valid = 1; rd increments.
    - When rd reaches N, no further loads occur.
  - DRAIN: entered when rd == N and the register still holds the last coefficient. Leaves when out_valid && out_ready && out_last.
    - Exit goes to IDLE; out_valid = 0; in_ready = 1 in the next cycle; busy = 0.
  - If the last handshake occurs on the same edge as the transition, RUN goes straight to IDLE.
- Latency: first out_valid one cycle after the accept edge.
  - With out_ready held at 1: 16 consecutive outputs on cycles 1..16 after accept, and in_ready high on cycle 17.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable and rd does not advance.
  - There are no bubbles once out_ready returns.
- Arithmetic:
  - Product width is 30 bits (65535*7201 < 2^29), reduced combinationally mod Q before the output register.
  - Inputs ≥ Q are legal; the result equals ((coef mod Q) * NINV) mod Q.
  - Sole stage, single cycle. Must close timing with a constant-divisor reduction (Barrett or a subtract chain) rather than a generic divider.
- Simultaneous events:
  - in_valid while busy: ignored, and the vector is not latched.
  - in_valid held high through the final handshake: the next vector is accepted only on an edge where in_ready = 1, i.e. one cycle after IDLE is re-entered. There is no same-cycle turnaround.
- out_ready toggling every cycle must still yield indices 0..15 exactly once, in order.

Decomposition:
- Package poly_pkg: Q, N, NINV, W, and the state encoding (IDLE, RUN, DRAIN). These are shared with the NTT/INTT and pointwise-multiply stages.
- Sub-module mod_mul_const: combinational (a * NINV) mod Q. Reusable by the pointwise multiplier stage.

Test Plan:
- Reset: assert rst = 0 mid-RUN at cycle 5 of a stream -> out_valid = 0, in_ready = 1 immediately; no further outputs until a new accept.
- Known values, out_ready = 1: in_coeffs = {0,1,16,7680,65535,...}, coefficients at indices 0..4 -> out_data 0, 7201, 1, 480, 4576 at indices 0..4.
  - Outputs appear on cycles 1..5 after accept; out_last only at index 15; in_ready high on cycle 17.
- Backpressure: out_ready low for cycles 3–6 -> out_data and out_index frozen at index 2; the stream resumes at index 3 with no duplicate or skipped index.
- Random out_ready: random in_coeffs, 50% out_ready -> scoreboard matches (c*7201)%7681 for all 16 coefficients, in order.
- Busy ignore: second vector presented with in_valid high during RUN -> no capture. It is accepted only after the first vector's last handshake plus one cycle; the first vector's outputs are unchanged.
- Back-to-back: two vectors with in_valid always high and out_ready = 1 -> 32 outputs with exactly one idle cycle (accept cycle) between streams.
